ps2_rx_buffered: RTL and testbench

// Parametrised PS/2 device-to-host frame receiver with input glitch filtering, programmable timeout and a

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_rx_fifo.sv | 54 +++++
 rtl/ps2_rx_buffered.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_rx_buffered.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, error-flag layout and FIFO entry width.
package ps2_pkg;

  localparam int BYTE_W  = 8;
  localparam int ERR_W   = 2;
  localparam int FRAME_W = BYTE_W + ERR_W;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } state_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rd_data whenever the FIFO is not empty.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A write into a full FIFO is accepted when the head is popped in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host frame receiver: pin synchronisers, glitch filters, framing FSM with timeout,
// and a receive FIFO carrying per-byte parity/stop error flags.
module ps2_rx_buffered
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          ODD_PARITY  = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PS2_CLK,
  input  logic              PS2_DATA,
  input  logic              RX_ENABLE,
  input  logic              RD_EN,
  output logic              RD_VALID,
  output logic [BYTE_W-1:0] RD_DATA,
  output logic [ERR_W-1:0]  RD_ERR,
  output logic              FIFO_FULL,
  output logic              OVERFLOW,
  output logic              TIMEOUT
);

  localparam int unsigned FCW  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
  logic [1:0]     sync_0;
  logic [1:0]     sync_1;
  logic [1:0]     filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_prev;
  logic           fall;
  logic           data_f;

  state_t              state;
  state_t              state_n;
  logic [2:0]          bit_cnt;
  logic [BYTE_W-1:0]   shreg;
  logic [ERR_W-1:0]    err;
  logic [TO_W-1:0]     to_cnt;
  logic                to_hit;
  logic                abort;
  logic                start;

  logic                push_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FRAME_W-1:0]  fifo_rd_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_0 <= 2'b11;
      sync_1 <= 2'b11;
    end else begin
      sync_0 <= {PS2_DATA, PS2_CLK};
      sync_1 <= sync_0;
    end
  end

  // Filtered output only flips after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
          filt[i] <= sync_1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) clk_prev <= 1'b1;
    else       clk_prev <= filt[0];
  end

  assign fall   = clk_prev && !filt[0];
  assign data_f = filt[1];
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign start  = fall && RX_ENABLE && !data_f;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n  = state;
    abort    = 1'b0;
    push_req = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (fall) begin
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end else if (to_hit) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          state_n = ST_STOP;
        end else if (to_hit) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_n = ST_PUSH;
        end else if (to_hit) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_PUSH: begin
        push_req = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt <= '0;
      shreg   <= '0;
      err     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            err     <= '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shreg   <= {data_f, shreg[BYTE_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (fall) err[ERR_PARITY] <= ((^shreg) ^ data_f) != ODD_PARITY;
        end
        ST_STOP: begin
          if (fall) err[ERR_STOP] <= !data_f;
        end
        default: ;
      endcase
    end
  end

  // Measures idle time since the last falling edge; saturates rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RESET || state == ST_IDLE || fall) begin
      to_cnt <= '0;
    end else if (to_cnt != '1) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      TIMEOUT  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      TIMEOUT <= abort;
      if (push_req && fifo_full && !(RD_EN && !fifo_empty)) OVERFLOW <= 1'b1;
    end
  end

  ps2_rx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (push_req),
    .wr_data ({err, shreg}),
    .rd_en   (RD_EN),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign RD_VALID  = !fifo_empty;
  assign RD_DATA   = fifo_rd_data[BYTE_W-1:0];
  assign RD_ERR    = fifo_rd_data[FRAME_W-1:BYTE_W];
  assign FIFO_FULL = fifo_full;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed bench for ps2_rx_buffered: PS/2 frames are bit-banged on the pins and the FIFO output checked.
module tb_ps2_rx_buffered;
  import ps2_pkg::*;

  localparam int TO_CYC = 300;
  localparam int HALF   = 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       RX_ENABLE = 1'b1;
  logic       RD_EN = 1'b0;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic [1:0] RD_ERR;
  logic       FIFO_FULL;
  logic       OVERFLOW;
  logic       TIMEOUT;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_rx_buffered #(
    .TIMEOUT_CYC (TO_CYC),
    .FILT_LEN    (4),
    .FIFO_DEPTH  (4),
    .ODD_PARITY  (1'b1)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .RX_ENABLE (RX_ENABLE),
    .RD_EN     (RD_EN),
    .RD_VALID  (RD_VALID),
    .RD_DATA   (RD_DATA),
    .RD_ERR    (RD_ERR),
    .FIFO_FULL (FIFO_FULL),
    .OVERFLOW  (OVERFLOW),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  // Sends the first nbits bits of {stop, parity, byte, start}; a full frame also idles the bus after.
  task automatic ps2_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    PS2_DATA = 1'b1;
    if (nbits == 11) repeat (2 * HALF) @(negedge CLK);
  endtask

  task automatic pop_one();
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [7:0] d, input logic [1:0] e);
    n_checks++;
    if (RD_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid: got %b want 1", name, RD_VALID);
    end
    n_checks++;
    if (RD_DATA !== d) begin
      n_fail++;
      $display("FAIL %s data: got %h want %h", name, RD_DATA, d);
    end
    n_checks++;
    if (RD_ERR !== e) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b", name, RD_ERR, e);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    expect_bit("reset rd_valid", RD_VALID, 1'b0);
    n_checks++;
    if ({RD_ERR, RD_DATA} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset head: got %h want 000", {RD_ERR, RD_DATA});
    end
    expect_bit("reset fifo_full", FIFO_FULL, 1'b0);
    expect_bit("reset overflow", OVERFLOW, 1'b0);
    expect_bit("reset timeout", TIMEOUT, 1'b0);
  endtask

  task automatic test_good_frame();
    ps2_frame(8'h5A, 1'b1, 1'b1, 11);
    expect_head("frame 5A", 8'h5A, 2'b00);
    pop_one();
    expect_bit("frame 5A popped", RD_VALID, 1'b0);
  endtask

  task automatic test_error_frame();
    ps2_frame(8'h00, 1'b0, 1'b0, 11);
    expect_head("frame 00 bad", 8'h00, 2'b11);
    pop_one();
    expect_bit("frame 00 popped", RD_VALID, 1'b0);
  endtask

  task automatic test_glitch();
    PS2_DATA = 1'b0;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (2 * HALF) @(negedge CLK);
    n_checks++;
    if (dut.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL glitch state: got %0d want %0d", dut.state, ST_IDLE);
    end
    expect_bit("glitch rd_valid", RD_VALID, 1'b0);
    PS2_DATA = 1'b1;
    repeat (HALF) @(negedge CLK);
    ps2_frame(8'h12, 1'b1, 1'b1, 11);
    expect_head("frame 12 after glitch", 8'h12, 2'b00);
    pop_one();
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    ps2_frame(8'hFF, 1'b0, 1'b1, 5);
    for (int i = 0; i < TO_CYC + 100; i++) begin
      @(negedge CLK);
      if (TIMEOUT === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout pulses: got %0d want 1", pulses);
    end
    expect_bit("timeout fifo empty", RD_VALID, 1'b0);
    ps2_frame(8'hA5, 1'b1, 1'b1, 11);
    expect_head("frame A5 after timeout", 8'hA5, 2'b00);
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      ps2_frame(b, ~^b, 1'b1, 11);
    end
    expect_bit("overflow fifo_full", FIFO_FULL, 1'b1);
    expect_bit("overflow flag", OVERFLOW, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      expect_head($sformatf("drain %0d", i), 8'(i), 2'b00);
      pop_one();
    end
    expect_bit("drained rd_valid", RD_VALID, 1'b0);
    expect_bit("overflow sticky", OVERFLOW, 1'b1);
  endtask

  task automatic test_reset_midframe();
    ps2_frame(8'h11, 1'b1, 1'b1, 11);
    ps2_frame(8'h22, 1'b1, 1'b1, 11);
    expect_head("pre-reset head", 8'h11, 2'b00);
    ps2_frame(8'h77, 1'b0, 1'b1, 7);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    expect_bit("post-reset rd_valid", RD_VALID, 1'b0);
    expect_bit("post-reset overflow", OVERFLOW, 1'b0);
    expect_bit("post-reset fifo_full", FIFO_FULL, 1'b0);
    repeat (HALF) @(negedge CLK);
    ps2_frame(8'h3C, 1'b1, 1'b1, 11);
    expect_head("frame 3C after reset", 8'h3C, 2'b00);
    pop_one();
    expect_bit("final empty", RD_VALID, 1'b0);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_good_frame();
    test_error_frame();
    test_glitch();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
